lsu_mem_responder: RTL
======================

Name: lsu_mem_responder

Overview:
- Data-memory responder at the far end of the LSU memory interface. It services mem_ren/mem_raddr read requests and mem_wen/mem_waddr/mem_wdata write requests from the load/store functional unit.
- Reads return on mem_rvalid/mem_rdata after a fixed, parameterised latency. Writes commit into an internal word-addressed RAM.
- Used as the data memory in core-level simulation and on FPGA. It has no back-pressure: every request is accepted in the cycle it is presented.

Parameters:
- DEPTH_WORDS, 1024, number of 64-bit words in the RAM; power of two, at least 2.
- READ_LATENCY, 2, cycles from a read request to mem_rvalid; range 1..8.
- BASE_ADDR, 64'h0, byte address of word 0.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- mem_ren  input  1  read request, this cycle
- mem_raddr  input  64  read byte address
- mem_rvalid  output  1  read response valid (one-cycle pulse per request)
- mem_rdata  output  64  read response data
- mem_rerr  output  1  qualifies mem_rvalid: request was misaligned or out of range
- mem_wen  input  1  write request, this cycle
- mem_waddr  input  64  write byte address
- mem_wdata  input  64  write data
- err_count  output  16  saturating count of rejected reads plus rejected writes
- inflight  output  4  reads accepted but not yet returned

Behaviour:
- Address decode: off = addr - BASE_ADDR (64-bit, wrap allowed). An address is legal iff off[2:0]==0 and off[63:3] < DEPTH_WORDS. Word index = off[$clog2(DEPTH_WORDS)+2:3].
- Write: if mem_wen is high and the address is legal, RAM[index] takes mem_wdata at the rising edge. If illegal, no RAM change and err_count increments.
- Read acceptance: if mem_ren is high, a response is pushed into a READ_LATENCY-deep shift pipeline carrying {valid, err, data}.
  - Data is sampled in the accept cycle.
  - If mem_wen targets the same legal index in that cycle, the read returns mem_wdata (write-first forwarding).
  - Illegal reads carry err=1, data=0, and increment err_count.
- Response: the entry pushed at edge N appears on outputs (registered) such that mem_rvalid is high exactly READ_LATENCY cycles after the mem_ren cycle. mem_rdata and mem_rerr are valid only with mem_rvalid; otherwise mem_rdata=0 and mem_rerr=0.
- Throughput and ordering: one read and one write per cycle, simultaneously, to any addresses. Responses return strictly in request order. Back-to-back reads produce back-to-back rvalid pulses.
- A write issued after a read's accept cycle never affects that read's data, even while the read is in flight.
- err_count:
  - +1 per illegal read, +1 per illegal write; +2 if both occur in the same cycle.
  - Saturates at 16'hFFFF and never wraps.
- inflight:
  - +1 on accept, -1 on return; unchanged if both occur in the same cycle.
  - Always equals the number of valid pipeline entries.
  - Maximum value is READ_LATENCY.
- Reset (async assert, synchronous-to-clk deassert handled upstream):
  - Clears mem_rvalid=0, mem_rdata=0, mem_rerr=0, err_count=0, inflight=0, and all pipeline valid bits.
  - In-flight reads are discarded and never return.
  - RAM contents are not reset and are retained across reset; they are undefined at power-up.
  - Requests presented while rst is high are ignored: no write, no response, no count.
- Simultaneous illegal read and legal write in the same cycle: the write commits and the read errors independently.

Test Plan:
- Write 64'hDEAD_BEEF_0000_0001 to 0x40, then idle, then read 0x40 -> mem_rvalid exactly 2 cycles after mem_ren, mem_rdata=64'hDEAD_BEEF_0000_0001, mem_rerr=0.
- Same cycle: wen to 0x80 with 64'h55, ren of 0x80 -> response data 64'h55 (forwarded). A next-cycle write of 64'h66 to 0x80 does not alter that in-flight response.
- Four consecutive reads of 0x0, 0x8, 0x10, 0x18 preloaded with 1, 2, 3, 4 -> four consecutive rvalid pulses with data 1, 2, 3, 4; inflight peaks at 2.
- Read 0x44 (misaligned) and read 0x2000 (DEPTH_WORDS=1024, out of range) -> rvalid with mem_rerr=1, data 0; err_count=2. An illegal write to 0x3 -> err_count=3 and RAM unchanged.
- Assert rst one cycle after a read to 0x40 -> no rvalid ever appears for it, inflight=0. After release, reading 0x40 returns the pre-reset contents.
- Force err_count to 16'hFFFE via 3 illegal accesses after preload of the counter state (or 65537 illegal writes) -> counter holds at 16'hFFFF.

Source files
------------

// File: rtl/lsu_mem_responder.sv
// ---------------------------------------------------------------------------
// lsu_mem_responder
//
// Data-memory responder at the far end of the LSU memory interface. Services
// one read and one write per cycle with no back-pressure. Writes commit into
// a word-addressed 64-bit RAM. Reads travel down a READ_LATENCY-deep shift
// pipeline and come back in request order on mem_rvalid/mem_rdata/mem_rerr.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   mem_ren         read request this cycle
//   mem_raddr       read byte address
//   mem_rvalid      one-cycle response pulse per read, READ_LATENCY later
//   mem_rdata       response data (0 when mem_rvalid is low or on error)
//   mem_rerr        response was misaligned or out of range
//   mem_wen         write request this cycle
//   mem_waddr       write byte address
//   mem_wdata       write data
//   err_count       saturating count of rejected reads plus rejected writes
//   inflight        reads accepted but not yet returned
// ---------------------------------------------------------------------------
module lsu_mem_responder #(
  parameter int unsigned DEPTH_WORDS  = 1024,
  parameter int unsigned READ_LATENCY = 2,
  parameter logic [63:0] BASE_ADDR    = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ren,
  input  logic [63:0] mem_raddr,
  output logic        mem_rvalid,
  output logic [63:0] mem_rdata,
  output logic        mem_rerr,
  input  logic        mem_wen,
  input  logic [63:0] mem_waddr,
  input  logic [63:0] mem_wdata,
  output logic [15:0] err_count,
  output logic [3:0]  inflight
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [63:0] data;
  } rsp_t;

  // -------------------------------------------------------------------------
  // Address decode (offset from BASE_ADDR, wrap allowed)
  // -------------------------------------------------------------------------
  logic [63:0]   roff, woff;
  logic          r_legal, w_legal;
  logic [AW-1:0] r_idx, w_idx;

  assign roff    = mem_raddr - BASE_ADDR;
  assign woff    = mem_waddr - BASE_ADDR;
  assign r_legal = (roff[2:0] == 3'b000) && (roff[63:3] < 61'(DEPTH_WORDS));
  assign w_legal = (woff[2:0] == 3'b000) && (woff[63:3] < 61'(DEPTH_WORDS));
  assign r_idx   = roff[AW+2:3];
  assign w_idx   = woff[AW+2:3];

  logic wr_commit;
  assign wr_commit = mem_wen && w_legal;

  // -------------------------------------------------------------------------
  // RAM
  // -------------------------------------------------------------------------
  logic [63:0] ram [DEPTH_WORDS];

  // NOTE: the RAM array has no reset so it maps onto block/distributed RAM and
  // keeps its contents across rst; rst only blocks writes while asserted.
  always_ff @(posedge clk) begin
    if (!rst && wr_commit) begin
      ram[w_idx] <= mem_wdata;
    end
  end

  // Read data is captured in the accept cycle; a same-cycle write to the same
  // word is forwarded so the read sees the new value (write-first).
  logic [63:0] rd_word;
  rsp_t        push;

  always_comb begin
    rd_word = ram[r_idx];
    if (wr_commit && (w_idx == r_idx)) begin
      rd_word = mem_wdata;
    end
    push       = '0;
    push.valid = mem_ren;
    push.err   = mem_ren && !r_legal;
    if (mem_ren && r_legal) begin
      push.data = rd_word;
    end
  end

  // -------------------------------------------------------------------------
  // Response pipeline: stage 0 loads at the edge after the request, the last
  // stage drives the outputs directly, giving exactly READ_LATENCY cycles.
  // Invalid entries carry zero data/err so the outputs need no extra gating.
  // -------------------------------------------------------------------------
  rsp_t pipe [READ_LATENCY];

  // NOTE: sequential state uses non-blocking assignments so every stage reads
  // the value of its predecessor from before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(READ_LATENCY); i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0] <= push;
      for (int i = 1; i < int'(READ_LATENCY); i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign mem_rvalid = pipe[READ_LATENCY-1].valid;
  assign mem_rerr   = pipe[READ_LATENCY-1].err;
  assign mem_rdata  = pipe[READ_LATENCY-1].data;

  // -------------------------------------------------------------------------
  // inflight: tracks the number of valid pipeline entries. An entry leaves at
  // the edge after it is presented on the outputs.
  // -------------------------------------------------------------------------
  logic retire;
  assign retire = pipe[READ_LATENCY-1].valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= '0;
    end else begin
      case ({mem_ren, retire})
        2'b10:   inflight <= inflight + 4'd1;
        2'b01:   inflight <= inflight - 4'd1;
        default: inflight <= inflight;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // err_count: adds 0, 1 or 2 per cycle and saturates at all-ones.
  // -------------------------------------------------------------------------
  logic [1:0]  err_inc;
  logic [16:0] err_sum;

  assign err_inc = {1'b0, (mem_ren && !r_legal)} + {1'b0, (mem_wen && !w_legal)};
  assign err_sum = {1'b0, err_count} + {15'd0, err_inc};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
    end else begin
      err_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
  end

endmodule
